// File: rtl/lif_spike_neuron_if.sv
// lif_spike_neuron_if: control, spike-input and membrane-output bundle of the LIF neuron
interface lif_spike_neuron_if #(
    parameter int N_IN        = 4,
    parameter int W_BITS      = 4,
    parameter int V_BITS      = 8,
    parameter int REFRAC_BITS = 3
);
    logic                     enable;
    logic [N_IN-1:0]          spikes_in;
    logic [N_IN*W_BITS-1:0]   weights;
    logic [V_BITS-1:0]        threshold;
    logic [2:0]               leak_shift;
    logic [REFRAC_BITS-1:0]   refrac_cycles;
    logic                     spike_out;
    logic [V_BITS-1:0]        membrane;
    logic                     refractory;
    modport master (
        output enable, spikes_in, weights, threshold, leak_shift, refrac_cycles,
        input  spike_out, membrane, refractory
    );
    modport slave (
        input  enable, spikes_in, weights, threshold, leak_shift, refrac_cycles,
        output spike_out, membrane, refractory
    );
endinterface

// File: rtl/lif_spike_neuron.sv
// lif_spike_neuron: leaky integrate-and-fire neuron with saturating membrane
// and a programmable refractory period after each spike.
module lif_spike_neuron #(
    parameter int N_IN        = 4,
    parameter int W_BITS      = 4,
    parameter int V_BITS      = 8,
    parameter int REFRAC_BITS = 3
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    lif_spike_neuron_if.slave    bus
);
    localparam int IW = V_BITS + W_BITS + 5;
    localparam logic signed [IW-1:0] VMAX = IW'((2 ** (V_BITS - 1)) - 1);
    localparam logic signed [IW-1:0] VMIN = -IW'(2 ** (V_BITS - 1));
    typedef enum logic {INTEGRATE, REFRACTORY} state_e;
    state_e                    r_state, w_state_nxt;
    logic signed [V_BITS-1:0]  r_v;
    logic [REFRAC_BITS-1:0]    r_cnt;
    logic                      r_spike;
    logic signed [IW-1:0]      w_sum, w_v_ext, w_leak, w_raw;
    logic signed [V_BITS-1:0]  w_vnext;
    logic                      w_fire;
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_IN; i++)
            w_sum = bus.spikes_in[i] ? w_sum + IW'(signed'(bus.weights[i*W_BITS +: W_BITS])) : w_sum;
    end
    assign w_v_ext = IW'(r_v);
    assign w_leak  = w_v_ext >>> bus.leak_shift;
    assign w_raw   = w_v_ext - w_leak + w_sum;
    assign w_vnext = w_raw > VMAX ? VMAX[V_BITS-1:0] : w_raw < VMIN ? VMIN[V_BITS-1:0] : w_raw[V_BITS-1:0];
    assign w_fire  = r_state == INTEGRATE && w_vnext >= $signed(bus.threshold);
    always_ff @(posedge sys_clk) begin
        if (reset) r_state <= INTEGRATE;
        else       r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = !bus.enable ? r_state :
                      r_state == INTEGRATE ? ((w_fire && bus.refrac_cycles != '0) ? REFRACTORY : INTEGRATE) :
                      (r_cnt == REFRAC_BITS'(1) ? INTEGRATE : REFRACTORY);
    end
    // refractory cycles count down from the value latched at the firing edge
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_v     <= '0;
            r_cnt   <= '0;
            r_spike <= 1'b0;
        end else begin
            r_spike <= bus.enable && w_fire;
            if (bus.enable) begin
                r_v   <= (r_state == REFRACTORY || w_fire) ? '0 : w_vnext;
                r_cnt <= r_state == REFRACTORY ? r_cnt - 1'b1 : w_fire ? bus.refrac_cycles : r_cnt;
            end
        end
    end
    always_comb begin
        bus.spike_out  = r_spike;
        bus.membrane   = r_v;
        bus.refractory = r_state == REFRACTORY;
    end
endmodule

// File: tb/tb_lif_spike_neuron.sv
// tb_lif_spike_neuron: directed vectors with hand-computed membrane, spike and
// refractory values for the default 4-input, 8-bit neuron.
module tb_lif_spike_neuron;
    logic sys_clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    lif_spike_neuron_if #(.N_IN(4), .W_BITS(4), .V_BITS(8), .REFRAC_BITS(3)) bus ();
    lif_spike_neuron #(.N_IN(4), .W_BITS(4), .V_BITS(8), .REFRAC_BITS(3)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );
    always #5 sys_clk = ~sys_clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input int mem, input int spk, input int refr);
        chk({tag, " membrane"}, int'($signed(bus.membrane)), mem);
        chk({tag, " spike"}, int'(bus.spike_out), spk);
        chk({tag, " refractory"}, int'(bus.refractory), refr);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    task automatic setup(input logic [3:0] w, input logic [3:0] sp, input logic [2:0] sh,
                         input int thr, input logic [2:0] rc);
        bus.weights       = {4{w}};
        bus.spikes_in     = sp;
        bus.leak_shift    = sh;
        bus.threshold     = 8'(thr);
        bus.refrac_cycles = rc;
    endtask
    int seq4[6] = '{-32, -63, -94, -125, -128, -128};
    int seq5[7] = '{28, 14, 7, 4, 2, 1, 1};
    initial begin
        reset      = 1'b1;
        bus.enable = 1'b1;
        setup(4'd3, 4'b1111, 3'd7, 10, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("reset hold", 0, 0, 0);
        end
        reset = 1'b0;
        setup(4'd3, 4'b0001, 3'd7, 10, 3'd0);
        for (int r = 0; r < 2; r++) begin
            tick(); expect_out("int 3", 3, 0, 0);
            tick(); expect_out("int 6", 6, 0, 0);
            tick(); expect_out("int 9", 9, 0, 0);
            tick(); expect_out("fire", 0, 1, 0);
        end
        bus.refrac_cycles = 3'd2;
        tick(); tick(); tick();
        expect_out("pre-refrac 9", 9, 0, 0);
        tick(); expect_out("refrac fire", 0, 1, 1);
        tick(); expect_out("refrac 2nd", 0, 0, 1);
        tick(); expect_out("refrac end", 0, 0, 0);
        tick(); expect_out("resume", 3, 0, 0);
        do_reset();
        setup(4'h8, 4'b1111, 3'd7, 100, 3'd0);
        foreach (seq4[k]) begin
            tick();
            expect_out("saturate", seq4[k], 0, 0);
        end
        do_reset();
        setup(4'd7, 4'b1111, 3'd7, 100, 3'd0);
        tick(); expect_out("charge 28", 28, 0, 0);
        tick(); expect_out("charge 56", 56, 0, 0);
        bus.spikes_in  = 4'b0000;
        bus.leak_shift = 3'd1;
        foreach (seq5[k]) begin
            tick();
            expect_out("leak", seq5[k], 0, 0);
        end
        do_reset();
        setup(4'd3, 4'b0001, 3'd7, 10, 3'd3);
        tick(); expect_out("gate int 3", 3, 0, 0);
        bus.enable = 1'b0;
        tick(); expect_out("gate hold a", 3, 0, 0);
        tick(); expect_out("gate hold b", 3, 0, 0);
        bus.enable = 1'b1;
        tick(); expect_out("gate int 6", 6, 0, 0);
        tick(); expect_out("gate int 9", 9, 0, 0);
        tick(); expect_out("gate fire", 0, 1, 1);
        bus.enable = 1'b0;
        tick(); expect_out("spike clears", 0, 0, 1);
        bus.enable = 1'b1;
        tick(); expect_out("refrac r1", 0, 0, 1);
        bus.enable        = 1'b0;
        bus.refrac_cycles = 3'd0;
        tick(); expect_out("refrac frozen a", 0, 0, 1);
        tick(); expect_out("refrac frozen b", 0, 0, 1);
        bus.enable = 1'b1;
        tick(); expect_out("refrac r2", 0, 0, 1);
        tick(); expect_out("refrac r3 done", 0, 0, 0);
        setup(4'd3, 4'b0000, 3'd7, -5, 3'd0);
        tick(); expect_out("neg thr fire a", 0, 1, 0);
        tick(); expect_out("neg thr fire b", 0, 1, 0);
        setup(4'd3, 4'b0001, 3'd7, 0, 3'd2);
        tick(); expect_out("zero thr fire", 0, 1, 1);
        tick(); expect_out("zero thr refrac", 0, 0, 1);
        reset = 1'b1;
        tick(); expect_out("reset in refrac", 0, 0, 0);
        reset = 1'b0;
        bus.threshold = 8'd10;
        tick(); expect_out("after reset int", 3, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
